// File: rtl/wb_arbiter.sv
// Writeback-port arbiter: merges pipeline writeback with queued long-latency results onto the
// register-file write port. Define WB_ARB_BYPASS_EN for same-cycle LU writes when the queue is empty.
module wb_arbiter #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       pipe_we_i,
    input  logic [4:0]                 pipe_rd_i,
    input  logic [WIDTH-1:0]           pipe_wd_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_rd_i,
    input  logic [WIDTH-1:0]           lu_wd_i,
    output logic                       we3_o,
    output logic [4:0]                 a3_o,
    output logic [WIDTH-1:0]           wd3_o,
    output logic                       stall_o,
    output logic [$clog2(DEPTH):0]     pending_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    logic [4:0]       rd_mem   [DEPTH];
    logic [WIDTH-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] kill_reg, kill_next;
    logic [DEPTH-1:0] kill_hit;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [AGE_W-1:0] age_reg, age_next;

    logic head_valid, head_kill, head_live, full, age_max, stall_int;
    logic pipe_ok, lu_fire, push, pop, pipe_acc, bypass;

    assign head_valid = valid_reg[rd_ptr_reg];
    assign head_kill  = kill_reg[rd_ptr_reg];
    assign head_live  = head_valid & ~head_kill;
    assign full       = (count_reg == CNT_W'(DEPTH));
    assign age_max    = (age_reg == AGE_W'(MAX_WAIT));
    assign stall_int  = head_live & age_max & ~reset_i;
    assign pipe_ok    = pipe_we_i & (pipe_rd_i != 5'd0);
    assign lu_fire    = lu_valid_i & ~full & ~reset_i;

    assign lu_ready_o = reset_i | ~full;
    assign stall_o    = stall_int;
    assign pending_o  = reset_i ? '0 : count_reg;

    // Write-port selection; a killed head retires without touching the port.
    always_comb begin
        we3_o    = 1'b0;
        a3_o     = 5'd0;
        wd3_o    = '0;
        pop      = 1'b0;
        pipe_acc = 1'b0;
        bypass   = 1'b0;
        if (!reset_i) begin
            if (stall_int) begin
                we3_o = 1'b1;
                a3_o  = rd_mem[rd_ptr_reg];
                wd3_o = data_mem[rd_ptr_reg];
                pop   = 1'b1;
            end else if (pipe_ok) begin
                we3_o    = 1'b1;
                a3_o     = pipe_rd_i;
                wd3_o    = pipe_wd_i;
                pipe_acc = 1'b1;
                pop      = head_valid & head_kill;
            end else if (head_live) begin
                we3_o = 1'b1;
                a3_o  = rd_mem[rd_ptr_reg];
                wd3_o = data_mem[rd_ptr_reg];
                pop   = 1'b1;
            end else begin
                pop = head_valid;
            end
`ifdef WB_ARB_BYPASS_EN
            if (lu_fire && (lu_rd_i != 5'd0) && (count_reg == '0) && !pipe_acc) begin
                bypass = 1'b1;
                we3_o  = 1'b1;
                a3_o   = lu_rd_i;
                wd3_o  = lu_wd_i;
            end
`endif
        end
    end

    assign push = lu_fire & (lu_rd_i != 5'd0) & ~bypass;

    // A pipeline write supersedes every older queued result to the same register.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_kill
        assign kill_hit[gi] = pipe_acc & valid_reg[gi] & (rd_mem[gi] == pipe_rd_i);
    end

    always_comb begin
        valid_next = valid_reg;
        kill_next  = kill_reg | kill_hit;
        if (pop) begin
            valid_next[rd_ptr_reg] = 1'b0;
            kill_next[rd_ptr_reg]  = 1'b0;
        end
        // Applied after the kill update so a same-cycle push counts as younger.
        if (push) begin
            valid_next[wr_ptr_reg] = 1'b1;
            kill_next[wr_ptr_reg]  = 1'b0;
        end
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        age_next   = age_reg;
        if (pop)
            age_next = '0;
        else if (head_live && !age_max)
            age_next = age_reg + AGE_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_reg  <= '0;
            kill_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            age_reg    <= '0;
        end else begin
            valid_reg  <= valid_next;
            kill_reg   <= kill_next;
            count_reg  <= count_next;
            age_reg    <= age_next;
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= lu_rd_i;
            data_mem[wr_ptr_reg] <= lu_wd_i;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic compared
// cycle by cycle against a queue-based reference model.
module tb_wb_arbiter;
    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_rd = 5'd0;
    logic [31:0] pipe_wd = 32'd0;
    logic        lu_valid = 1'b0;
    logic        lu_ready;
    logic [4:0]  lu_rd = 5'd0;
    logic [31:0] lu_wd = 32'd0;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        stall;
    logic [2:0]  pending;

    wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .reset_i(rst),
        .pipe_we_i(pipe_we), .pipe_rd_i(pipe_rd), .pipe_wd_i(pipe_wd),
        .lu_valid_i(lu_valid), .lu_ready_o(lu_ready), .lu_rd_i(lu_rd), .lu_wd_i(lu_wd),
        .we3_o(we3), .a3_o(a3), .wd3_o(wd3), .stall_o(stall), .pending_o(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          kill;
    } ent_t;

    ent_t q[$];
    int   age = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict the port from the model, compare, advance the model.
    task automatic step(input bit r, input bit pwe, input logic [4:0] prd, input logic [31:0] pwd,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] lwd,
                        output bit fired);
        bit          e_we, e_stall, e_ready, fire, head_ok, pop, acc, byp, push;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        int          e_pend;
        @(negedge clk);
        rst = r; pipe_we = pwe; pipe_rd = prd; pipe_wd = pwd;
        lu_valid = lv; lu_rd = lrd; lu_wd = lwd;
        #1;
        e_we = 0; e_a3 = 0; e_wd = 0; e_stall = 0; pop = 0; acc = 0; byp = 0; head_ok = 0;
        e_ready = r ? 1'b1 : (q.size() < DEPTH);
        e_pend  = r ? 0 : q.size();
        fire    = lv && e_ready;
        if (!r) begin
            head_ok = (q.size() > 0) && !q[0].kill;
            e_stall = head_ok && (age == MAX_WAIT);
            if (e_stall) begin
                e_we = 1; e_a3 = q[0].rd; e_wd = q[0].data; pop = 1;
            end else if (pwe && prd != 0) begin
                e_we = 1; e_a3 = prd; e_wd = pwd; acc = 1;
                pop = (q.size() > 0) && q[0].kill;
            end else if (head_ok) begin
                e_we = 1; e_a3 = q[0].rd; e_wd = q[0].data; pop = 1;
            end else begin
                pop = (q.size() > 0);
            end
`ifdef WB_ARB_BYPASS_EN
            if (fire && lrd != 0 && q.size() == 0 && !acc) begin
                byp = 1; e_we = 1; e_a3 = lrd; e_wd = lwd;
            end
`endif
        end
        push = !r && fire && (lrd != 0) && !byp;

        check("we3", we3, e_we);
        check("a3", a3, e_a3);
        check("wd3", wd3, e_wd);
        check("stall", stall, e_stall);
        check("lu_ready", lu_ready, e_ready);
        check("pending", pending, e_pend);
        if (e_we || fire || r)
            $display("[TB] cyc %0d rst=%0b we3=%0b a3=%0d wd3=%h stall=%0b lu_xfer=%0b rd=%0d pend=%0d",
                     cyc, r, we3, a3, wd3, stall, fire, lrd, pending);

        if (r) begin
            q.delete();
            age = 0;
        end else begin
            if (acc)
                foreach (q[k]) if (q[k].rd == prd) q[k].kill = 1;
            if (pop) begin
                void'(q.pop_front());
                age = 0;
            end else if (head_ok && age < MAX_WAIT) begin
                age++;
            end
            if (push)
                q.push_back('{rd: lrd, data: lwd, kill: 1'b0});
        end
        fired = fire;
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        bit          f;
        bit          lv;
        logic [4:0]  lrd;
        logic [31:0] lwd;
        bit          pwe;
        logic [4:0]  prd;

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, f);
        step(1, 1, 5'd4, 32'h1234, 1, 5'd2, 32'h55, f);
        step(0, 0, 0, 0, 0, 0, 0, f);

        // Idle drain
        step(0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF, f);
        step(0, 0, 0, 0, 0, 0, 0, f);
        step(0, 0, 0, 0, 0, 0, 0, f);

        // Fill and backpressure while the pipeline owns the port, then starvation relief
        for (int i = 0; i < 4; i++)
            step(0, 1, 5'd3, 32'h300 + i, 1, 5'(10 + i), 32'hA0 + i, f);
        for (int i = 0; i < 14; i++)
            step(0, 1, 5'd3, 32'h400 + i, 1, 5'd14, 32'hA4, f);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 0, 0, 0, f);

        // Starvation of a single entry
        step(0, 1, 5'd3, 32'h500, 1, 5'd7, 32'h77, f);
        for (int i = 0; i < 12; i++)
            step(0, 1, 5'd3, 32'h600 + i, 0, 0, 0, f);
        step(0, 0, 0, 0, 0, 0, 0, f);

        // WAW kill
        step(0, 1, 5'd3, 32'h700, 1, 5'd9, 32'h11, f);
        step(0, 1, 5'd9, 32'h22, 0, 0, 0, f);
        step(0, 0, 0, 0, 0, 0, 0, f);
        step(0, 0, 0, 0, 0, 0, 0, f);

        // x0 handling
        step(0, 0, 0, 0, 1, 5'd0, 32'hBAD, f);
        step(0, 1, 5'd3, 32'h800, 1, 5'd6, 32'h66, f);
        step(0, 1, 5'd0, 32'h900, 0, 0, 0, f);
        step(0, 0, 0, 0, 0, 0, 0, f);

        // Reset mid-operation
        for (int i = 0; i < 3; i++)
            step(0, 1, 5'd3, 32'hA00 + i, 1, 5'(20 + i), 32'hC0 + i, f);
        step(1, 1, 5'd3, 32'hB00, 0, 0, 0, f);
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 0, 0, 0, 0, f);

        // Randomized traffic with a held LU handshake
        lv = 0; lrd = 0; lwd = 0;
        for (int i = 0; i < 2000; i++) begin
            int phase;
            bit r;
            phase = i / 500;
            if (phase == 1) begin
                pwe = ($urandom_range(0, 99) < 97);
                prd = 5'($urandom_range(1, 7));
            end else begin
                pwe = ($urandom_range(0, 99) < 50);
                prd = (phase == 3) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            end
            if (!lv) begin
                lv  = ($urandom_range(0, 99) < 60);
                lrd = 5'($urandom_range(0, 7));
                lwd = $urandom;
            end
            r = ($urandom_range(0, 199) == 0);
            step(r, pwe, prd, $urandom, lv, lrd, lwd, f);
            if (f) lv = 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
